// File: rtl/ponto_triangulo_seq.sv
// Sequenced point-in-triangle tester: one shared COORD_W x COORD_W multiplier
// evaluates the four doubled areas |det| (ABC, ABP, APC, PBC) over 24 cycles.
module ponto_triangulo_seq #(
  parameter  int COORD_W = 10,
  localparam int AREA_W  = 2 * COORD_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] xA,
  input  logic [COORD_W-1:0] yA,
  input  logic [COORD_W-1:0] xB,
  input  logic [COORD_W-1:0] yB,
  input  logic [COORD_W-1:0] xC,
  input  logic [COORD_W-1:0] yC,
  input  logic [COORD_W-1:0] xP,
  input  logic [COORD_W-1:0] yP,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_inside,
  output logic               out_degenerate,
  output logic [AREA_W-1:0]  out_area,
  output logic [1:0]         dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both high; valid never drops without ready, and rst overrides both sides.

  localparam int ACC_W = AREA_W + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [COORD_W-1:0] xa, ya, xb, yb, xc, yc, xp, yp;
  logic [1:0]         tri_idx;
  logic [2:0]         term_idx;
  logic signed [ACC_W-1:0] acc;
  logic [AREA_W-1:0]  area [4];

  logic [COORD_W-1:0] x0, y0, x1, y1, x2, y2;
  logic [COORD_W-1:0] mul_a, mul_b;
  logic               sub;
  logic [AREA_W-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext, acc_sum, abs_val;
  logic [AREA_W-1:0]  area_new;
  logic [AREA_W+1:0]  sum;
  logic               last_term;

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;
  assign last_term = (term_idx == 3'd5);

  // Vertex routing for the triangle currently being evaluated.
  always_comb begin
    x0 = xa; y0 = ya;
    x1 = xb; y1 = yb;
    x2 = xc; y2 = yc;
    case (tri_idx)
      2'd0: begin x0 = xa; y0 = ya; x1 = xb; y1 = yb; x2 = xc; y2 = yc; end
      2'd1: begin x0 = xa; y0 = ya; x1 = xb; y1 = yb; x2 = xp; y2 = yp; end
      2'd2: begin x0 = xa; y0 = ya; x1 = xp; y1 = yp; x2 = xc; y2 = yc; end
      default: begin x0 = xp; y0 = yp; x1 = xb; y1 = yb; x2 = xc; y2 = yc; end
    endcase
  end

  // Determinant expansion: three positive products then three negative ones.
  always_comb begin
    mul_a = x0;
    mul_b = y1;
    sub   = 1'b0;
    case (term_idx)
      3'd0: begin mul_a = x0; mul_b = y1; sub = 1'b0; end
      3'd1: begin mul_a = y0; mul_b = x2; sub = 1'b0; end
      3'd2: begin mul_a = x1; mul_b = y2; sub = 1'b0; end
      3'd3: begin mul_a = x2; mul_b = y1; sub = 1'b1; end
      3'd4: begin mul_a = y2; mul_b = x0; sub = 1'b1; end
      default: begin mul_a = x1; mul_b = y0; sub = 1'b1; end
    endcase
  end

  always_comb begin
    prod     = mul_a * mul_b;
    prod_ext = signed'({{(ACC_W-AREA_W){1'b0}}, prod});
    acc_sum  = sub ? (acc - prod_ext) : (acc + prod_ext);
    abs_val  = acc_sum[ACC_W-1] ? -acc_sum : acc_sum;
    area_new = AREA_W'(abs_val);
    sum      = {2'b00, area[1]} + {2'b00, area[2]} + {2'b00, area[3]};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = MUL;
      MUL:  if (last_term && (tri_idx == 2'd3)) state_next = CMP;
      CMP:  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      xa <= '0; ya <= '0; xb <= '0; yb <= '0;
      xc <= '0; yc <= '0; xp <= '0; yp <= '0;
      tri_idx        <= '0;
      term_idx       <= '0;
      acc            <= '0;
      area[0]        <= '0;
      area[1]        <= '0;
      area[2]        <= '0;
      area[3]        <= '0;
      out_valid      <= 1'b0;
      out_inside     <= 1'b0;
      out_degenerate <= 1'b0;
      out_area       <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (in_valid) begin
            xa <= xA; ya <= yA; xb <= xB; yb <= yB;
            xc <= xC; yc <= yC; xp <= xP; yp <= yP;
            acc      <= '0;
            tri_idx  <= '0;
            term_idx <= '0;
          end
        end
        MUL: begin
          if (last_term) begin
            area[tri_idx] <= area_new;
            acc           <= '0;
            term_idx      <= '0;
            tri_idx       <= tri_idx + 2'd1;
          end else begin
            acc      <= acc_sum;
            term_idx <= term_idx + 3'd1;
          end
        end
        CMP: begin
          // P is inside (or on an edge) exactly when the sub-areas do not exceed ABC.
          out_inside     <= ({2'b00, area[0]} >= sum);
          out_degenerate <= (area[0] == '0);
          out_area       <= area[0];
          out_valid      <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ponto_triangulo_seq.sv
// Randomized and directed bench for ponto_triangulo_seq against an
// area-by-formula reference model with an expected-result queue.
module tb_ponto_triangulo_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  xA, yA, xB, yB, xC, yC, xP, yP;
  logic        out_valid;
  logic        out_ready;
  logic        out_inside;
  logic        out_degenerate;
  logic [19:0] out_area;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  logic [21:0] exp_q[$];

  ponto_triangulo_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .xA(xA), .yA(yA), .xB(xB), .yB(yB),
    .xC(xC), .yC(yC), .xP(xP), .yP(yP),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inside(out_inside), .out_degenerate(out_degenerate),
    .out_area(out_area), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int area2(input int x0, input int y0, input int x1,
                               input int y1, input int x2, input int y2);
    int d;
    d = (x1 - x0) * (y2 - y0) - (y1 - y0) * (x2 - x0);
    return (d < 0) ? -d : d;
  endfunction

  function automatic logic [79:0] pk(input int xa, input int ya, input int xb, input int yb,
                                     input int xc, input int yc, input int xp, input int yp);
    return {10'(xa), 10'(ya), 10'(xb), 10'(yb), 10'(xc), 10'(yc), 10'(xp), 10'(yp)};
  endfunction

  function automatic logic [21:0] model(input logic [79:0] c);
    int xa, ya, xb, yb, xc, yc, xp, yp;
    int a0, a1, a2, a3;
    logic [19:0] a0v;
    xa = int'(c[79:70]); ya = int'(c[69:60]); xb = int'(c[59:50]); yb = int'(c[49:40]);
    xc = int'(c[39:30]); yc = int'(c[29:20]); xp = int'(c[19:10]); yp = int'(c[9:0]);
    a0 = area2(xa, ya, xb, yb, xc, yc);
    a1 = area2(xa, ya, xb, yb, xp, yp);
    a2 = area2(xa, ya, xp, yp, xc, yc);
    a3 = area2(xp, yp, xb, yb, xc, yc);
    a0v = 20'(a0);
    return {(a0 >= a1 + a2 + a3), (a0 == 0), a0v};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scramble_inputs();
    {xA, yA, xB, yB, xC, yC, xP, yP} = {$urandom, $urandom, $urandom};
  endtask

  // Present a job at the current post-edge slot and let it be accepted.
  task automatic start_job(input logic [79:0] c);
    {xA, yA, xB, yB, xC, yC, xP, yP} = c;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL accept_ready: in_ready=%b expected 1", in_ready);
    end
    exp_q.push_back(model(c));
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  // Wait for the result after accept, checking latency and scoreboard fields.
  task automatic wait_result();
    int n;
    logic [21:0] e;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (in_ready !== 1'b0 && out_valid !== 1'b1) begin
        checks++; failures++;
        $display("FAIL busy_ready: in_ready=%b during job at cycle %0d", in_ready, n);
      end
    end
    checks++;
    if (n != 25) begin
      failures++;
      $display("FAIL latency: got %0d clocks expected 25", n);
    end
    if (out_valid !== 1'b1) return;
    e = exp_q.pop_front();
    checks++;
    if (out_area !== e[19:0]) begin
      failures++;
      $display("FAIL area: got %0d expected %0d", out_area, e[19:0]);
    end
    checks++;
    if (out_inside !== e[21]) begin
      failures++;
      $display("FAIL inside: got %b expected %b (area %0d)", out_inside, e[21], e[19:0]);
    end
    checks++;
    if (out_degenerate !== e[20]) begin
      failures++;
      $display("FAIL degenerate: got %b expected %b", out_degenerate, e[20]);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL consume: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic run_job(input logic [79:0] c);
    start_job(c);
    wait_result();
    consume();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    scramble_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    checks++;
    if ({in_ready, out_valid, out_inside, out_degenerate} !== 4'b1000 || out_area !== 20'd0
        || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL reset: rdy/vld/ins/deg=%b area=%0d state=%0d expected 1000/0/0",
               {in_ready, out_valid, out_inside, out_degenerate}, out_area, dbg_state);
    end
  endtask

  task automatic test_directed();
    logic [79:0] tbl[7];
    tbl[0] = pk(1, 1, 10, 10, 10, 1, 5, 4);
    tbl[1] = pk(1, 1, 10, 10, 10, 1, 2, 8);
    tbl[2] = pk(1, 1, 10, 10, 10, 1, 10, 1);
    tbl[3] = pk(1, 1, 10, 10, 10, 1, 5, 5);
    tbl[4] = pk(0, 0, 5, 5, 10, 10, 3, 3);
    tbl[5] = pk(0, 0, 5, 5, 10, 10, 3, 4);
    tbl[6] = pk(0, 0, 1023, 0, 0, 1023, 0, 0);
    foreach (tbl[i]) run_job(tbl[i]);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      int m;
      m = (i % 2 == 0) ? 15 : 1023;
      run_job(pk($urandom_range(0, m), $urandom_range(0, m), $urandom_range(0, m),
                 $urandom_range(0, m), $urandom_range(0, m), $urandom_range(0, m),
                 $urandom_range(0, m), $urandom_range(0, m)));
    end
  endtask

  task automatic test_back_to_back();
    logic [22:0] held;
    out_ready = 1'b0;
    start_job(pk(0, 0, 1023, 0, 0, 1023, 0, 0));
    wait_result();
    held = {out_valid, out_inside, out_degenerate, out_area};
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      scramble_inputs();
      @(posedge clk); #1;
      checks++;
      if ({out_valid, out_inside, out_degenerate, out_area} !== held || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold: outputs=%h in_ready=%b expected %h/0",
                 {out_valid, out_inside, out_degenerate, out_area}, in_ready, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    run_job(pk(2, 3, 900, 40, 300, 700, 400, 300));
  endtask

  task automatic test_reset_mid();
    start_job(pk(3, 7, 800, 900, 600, 20, 500, 500));
    repeat (11) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_area !== 20'd0 || dbg_state !== 2'd0) begin
      failures++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b area=%0d state=%0d expected 1/0/0/0",
               in_ready, out_valid, out_area, dbg_state);
    end
    run_job(pk(1, 1, 10, 10, 10, 1, 5, 4));
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left: %0d entries expected 0", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
